// File: rtl/nes_imm_pkg.sv
// Shared types for the immediate generator: mode encoding, halfword shift
// granularity and a small helper that classifies the move-wide modes.
package nes_imm_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_D    = 3'd1,
    IMM_CB   = 3'd2,
    IMM_B    = 3'd3,
    IMM_MOVZ = 3'd4,
    IMM_MOVN = 3'd5,
    IMM_MOVK = 3'd6,
    IMM_RSVD = 3'd7
  } imm_mode_t;

  // Move-wide immediates place a 16-bit chunk at a multiple of this offset.
  localparam int HW_SHIFT = 16;

  // True for the three move-wide modes that use the hw field.
  function automatic logic is_move(input imm_mode_t m);
    return (m == IMM_MOVZ) || (m == IMM_MOVN) || (m == IMM_MOVK);
  endfunction

endpackage

// File: rtl/imm_pipe_slice.sv
// One elastic register slice: holds a single W-bit payload and loads a new
// one whenever it is empty or its current contents are leaving this cycle.
module imm_pipe_slice #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         resetl,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         full_reg;
  logic [W-1:0] data_reg;

  // Ready passes straight through from downstream so a full slice that is
  // draining can refill in the same cycle without a bubble.
  assign in_ready  = !full_reg || out_ready;
  assign out_valid = full_reg;
  assign out_data  = data_reg;

  // Occupancy and payload update; payload only captured on a real transfer.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (in_ready) begin
      full_reg <= in_valid;
      if (in_valid) begin
        data_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator. Stage 1 extracts and extends the raw field
// and flags illegal requests; stage 2 applies the halfword shift, inversion
// or merge and produces the final value. The error counter lives here.
module imm_gen_pipe
  import nes_imm_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ERR_W  = 8
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [25:0]       instr,
  input  imm_mode_t         mode,
  input  logic [DATA_W-1:0] old_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_out,
  output logic              illegal,
  output logic [ERR_W-1:0]  err_cnt
);

  // Stage-1 payload: {illegal, mode, hw, old_val, field}
  localparam int S1_W = 2 * DATA_W + 6;
  localparam int S2_W = DATA_W + 1;

  logic              run_reg;
  logic [ERR_W-1:0]  err_cnt_reg;

  logic [1:0]        hw;
  logic [DATA_W-1:0] field_next;
  logic              illegal_next;

  logic              s1_in_valid, s1_in_ready, s1_out_valid, s2_in_ready;
  logic [S1_W-1:0]   s1_in_data, s1_out_data;

  logic [DATA_W-1:0] s1_field, s1_old;
  logic [1:0]        s1_hw;
  logic [2:0]        s1_mode;
  logic              s1_illegal;

  logic [5:0]        shamt;
  logic [DATA_W-1:0] shifted, lane_mask, result_next;
  logic [S2_W-1:0]   s2_out_data;

  // Holds the input side closed until the first clock after reset release.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  assign in_ready    = run_reg && s1_in_ready;
  assign s1_in_valid = run_reg && in_valid;
  assign hw          = instr[22:21];

  // Field extraction and sign/zero extension to the output width.
  always_comb begin
    field_next   = '0;
    illegal_next = 1'b0;
    case (mode)
      IMM_I:   field_next = {{(DATA_W-12){instr[21]}}, instr[21:10]};
      IMM_D:   field_next = {{(DATA_W-9){instr[20]}}, instr[20:12]};
      IMM_CB:  field_next = {{(DATA_W-21){instr[23]}}, instr[23:5], 2'b00};
      IMM_B:   field_next = {{(DATA_W-28){instr[25]}}, instr[25:0], 2'b00};
      IMM_MOVZ, IMM_MOVN, IMM_MOVK:
               field_next = {{(DATA_W-16){1'b0}}, instr[20:5]};
      default: illegal_next = 1'b1;
    endcase
    // A 32-bit result only has halfwords 0 and 1.
    if ((DATA_W == 32) && is_move(mode) && hw[1]) begin
      illegal_next = 1'b1;
    end
  end

  assign s1_in_data = {illegal_next, mode, hw, old_val, field_next};

  imm_pipe_slice #(.W(S1_W)) u_s1 (
    .CLK       (CLK),
    .resetl    (resetl),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_out_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_out_data)
  );

  assign s1_field   = s1_out_data[DATA_W-1:0];
  assign s1_old     = s1_out_data[2*DATA_W-1:DATA_W];
  assign s1_hw      = s1_out_data[2*DATA_W+1:2*DATA_W];
  assign s1_mode    = s1_out_data[2*DATA_W+4:2*DATA_W+2];
  assign s1_illegal = s1_out_data[2*DATA_W+5];

  assign shamt     = 6'(s1_hw) * 6'(HW_SHIFT);
  assign shifted   = s1_field << shamt;
  assign lane_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF} << shamt;

  // Halfword placement, inversion or merge; illegal requests force zero.
  always_comb begin
    result_next = s1_field;
    case (imm_mode_t'(s1_mode))
      IMM_MOVZ: result_next = shifted;
      IMM_MOVN: result_next = ~shifted;
      IMM_MOVK: result_next = (s1_old & ~lane_mask) | shifted;
      default:  result_next = s1_field;
    endcase
    if (s1_illegal) begin
      result_next = '0;
    end
  end

  imm_pipe_slice #(.W(S2_W)) u_s2 (
    .CLK       (CLK),
    .resetl    (resetl),
    .in_valid  (s1_out_valid),
    .in_ready  (s2_in_ready),
    .in_data   ({s1_illegal, result_next}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out_data)
  );

  assign imm_out = s2_out_data[DATA_W-1:0];
  assign illegal = s2_out_data[DATA_W];
  assign err_cnt = err_cnt_reg;

  // Count illegal results as they leave, sticking at all-ones.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      err_cnt_reg <= '0;
    end else if (out_valid && out_ready && illegal && (err_cnt_reg != '1)) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 64-bit/8-bit-counter instance and a 32-bit/2-bit-
// counter instance share stimulus; each has its own expected-result queue.
module tb_imm_gen_pipe;
  import nes_imm_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        resetl, in_valid, out_ready;
  logic [25:0] instr;
  imm_mode_t   mode;
  logic [63:0] old_val;

  logic        rdy64, ov64, ill64;
  logic [63:0] io64;
  logic [7:0]  err64;
  logic        rdy32, ov32, ill32;
  logic [31:0] io32;
  logic [1:0]  err32;

  imm_gen_pipe #(.DATA_W(64), .ERR_W(8)) u64 (
    .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .mode(mode), .old_val(old_val), .out_valid(ov64),
    .out_ready(out_ready), .imm_out(io64), .illegal(ill64), .err_cnt(err64)
  );

  imm_gen_pipe #(.DATA_W(32), .ERR_W(2)) u32 (
    .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .mode(mode), .old_val(old_val[31:0]), .out_valid(ov32),
    .out_ready(out_ready), .imm_out(io32), .illegal(ill32), .err_cnt(err32)
  );

  typedef struct {
    logic [63:0] val;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [2:0]  mode;
    logic [25:0] instr;
    logic [63:0] old;
    logic [63:0] e64;
    logic        i64;
    logic [31:0] e32;
    logic        i32;
  } vec_t;

  vec_t tbl[16];
  exp_t q64[$];
  exp_t q32[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int or_pat = 0;      // 0: always ready, 1: toggle 1010.., 2: stalled
  int since_rst = 0;
  int m_err64 = 0;
  int m_err32 = 0;
  logic        acc;
  logic        hold_v;
  logic [63:0] hold_val;
  logic [63:0] cur_e64;
  logic        cur_i64;
  logic [31:0] cur_e32;
  logic        cur_i32;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive out_ready, settle, check, account handshakes, step.
  task automatic do_cycle();
    exp_t e;
    case (or_pat)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 2 == 0);
      default: out_ready = 1'b0;
    endcase
    #1;
    chk("err_cnt64", 64'(err64), 64'(m_err64));
    chk("err_cnt32", 64'(err32), 64'(m_err32));
    if (hold_v) begin
      chk("hold_valid64", 64'(ov64), 64'd1);
      chk("hold_value64", io64, hold_val);
    end
    if (since_rst >= 1 && !rdy64) begin
      chk("in_ready_low_only_when_full", 64'(ov64 && !out_ready), 64'd1);
    end
    if (ov64 && out_ready) begin
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out64: got %h expected no output", io64);
      end else begin
        e = q64.pop_front();
        $display("txn out64 imm=%h illegal=%b", io64, ill64);
        chk("imm_out64", io64, e.val);
        chk("illegal64", 64'(ill64), 64'(e.ill));
        if (e.ill) m_err64 = (m_err64 == 255) ? 255 : m_err64 + 1;
      end
    end
    if (ov32 && out_ready) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out32: got %h expected no output", io32);
      end else begin
        e = q32.pop_front();
        $display("txn out32 imm=%h illegal=%b", io32, ill32);
        chk("imm_out32", 64'(io32), e.val);
        chk("illegal32", 64'(ill32), 64'(e.ill));
        if (e.ill) m_err32 = (m_err32 == 3) ? 3 : m_err32 + 1;
      end
    end
    acc = in_valid && rdy64;
    if (acc) q64.push_back('{cur_e64, cur_i64});
    if (in_valid && rdy32) q32.push_back('{64'(cur_e32), cur_i32});
    hold_v   = ov64 && !out_ready;
    hold_val = io64;
    @(negedge CLK);
    cyc++;
    since_rst++;
  endtask

  task automatic present(input logic [2:0] m, input logic [25:0] ins, input logic [63:0] old,
                         input logic [63:0] e64, input logic i64,
                         input logic [31:0] e32, input logic i32);
    in_valid = 1'b1;
    mode     = imm_mode_t'(m);
    instr    = ins;
    old_val  = old;
    cur_e64  = e64;
    cur_i64  = i64;
    cur_e32  = e32;
    cur_i32  = i32;
  endtask

  task automatic wait_accept();
    bit done = 0;
    for (int n = 0; n < 50; n++) begin
      do_cycle();
      if (acc) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic send(input logic [2:0] m, input logic [25:0] ins, input logic [63:0] old,
                      input logic [63:0] e64, input logic i64,
                      input logic [31:0] e32, input logic i32);
    present(m, ins, old, e64, i64, e32, i32);
    wait_accept();
  endtask

  task automatic drain();
    bit done = 0;
    in_valid = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (q64.size() == 0 && q32.size() == 0) begin
        done = 1;
        break;
      end
      do_cycle();
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q64.size(), q32.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3'd0, 26'h03F_FC00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
    tbl[1]  = '{3'd0, 26'h004_8C00, 64'h0, 64'h0000_0000_0000_0123, 1'b0, 32'h0000_0123, 1'b0};
    tbl[2]  = '{3'd1, 26'h010_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 32'hFFFF_FF00, 1'b0};
    tbl[3]  = '{3'd1, 26'h00A_B000, 64'h0, 64'h0000_0000_0000_00AB, 1'b0, 32'h0000_00AB, 1'b0};
    tbl[4]  = '{3'd2, 26'h080_0000, 64'h0, 64'hFFFF_FFFF_FFF0_0000, 1'b0, 32'hFFF0_0000, 1'b0};
    tbl[5]  = '{3'd2, 26'h000_2460, 64'h0, 64'h0000_0000_0000_048C, 1'b0, 32'h0000_048C, 1'b0};
    tbl[6]  = '{3'd3, 26'h200_0000, 64'h0, 64'hFFFF_FFFF_F800_0000, 1'b0, 32'hF800_0000, 1'b0};
    tbl[7]  = '{3'd3, 26'h000_0005, 64'h0, 64'h0000_0000_0000_0014, 1'b0, 32'h0000_0014, 1'b0};
    tbl[8]  = '{3'd4, 26'h035_79A0, 64'h0, 64'h0000_0000_ABCD_0000, 1'b0, 32'hABCD_0000, 1'b0};
    tbl[9]  = '{3'd4, 26'h062_4680, 64'h0, 64'h1234_0000_0000_0000, 1'b0, 32'h0, 1'b1};
    tbl[10] = '{3'd5, 26'h020_0020, 64'h0, 64'hFFFF_FFFF_FFFE_FFFF, 1'b0, 32'hFFFE_FFFF, 1'b0};
    tbl[11] = '{3'd5, 26'h040_0020, 64'h0, 64'hFFFF_FFFE_FFFF_FFFF, 1'b0, 32'h0, 1'b1};
    tbl[12] = '{3'd6, 26'h057_DDE0, 64'h1111_2222_3333_4444, 64'h1111_BEEF_3333_4444, 1'b0, 32'h0, 1'b1};
    tbl[13] = '{3'd6, 26'h017_DDE0, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_BEEF, 1'b0, 32'h3333_BEEF, 1'b0};
    tbl[14] = '{3'd6, 26'h02B_4B40, 64'h0, 64'h0000_0000_5A5A_0000, 1'b0, 32'h5A5A_0000, 1'b0};
    tbl[15] = '{3'd7, 26'h3FF_FFFF, 64'h0, 64'h0, 1'b1, 32'h0, 1'b1};

    resetl = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; mode = IMM_I; old_val = '0; hold_v = 1'b0; acc = 1'b0;
    cur_e64 = '0; cur_i64 = 1'b0; cur_e32 = '0; cur_i32 = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_in_ready64", 64'(rdy64), 64'd0);
    chk("rst_in_ready32", 64'(rdy32), 64'd0);
    chk("rst_out_valid64", 64'(ov64), 64'd0);
    chk("rst_imm_out64", io64, 64'd0);
    chk("rst_illegal64", 64'(ill64), 64'd0);
    chk("rst_err64", 64'(err64), 64'd0);
    @(negedge CLK);
    resetl = 1'b1;
    since_rst = 0;
    do_cycle();
    chk("in_ready_after_reset", 64'(rdy64), 64'd1);

    // Table of single requests, consumer always ready
    or_pat = 0;
    for (int i = 0; i < 16; i++) begin
      send(tbl[i].mode, tbl[i].instr, tbl[i].old, tbl[i].e64, tbl[i].i64, tbl[i].e32, tbl[i].i32);
    end
    drain();

    // Back-to-back B then CB stream with toggling consumer
    or_pat = 1;
    send(3'd3, 26'h200_0000, 64'h0, 64'hFFFF_FFFF_F800_0000, 1'b0, 32'hF800_0000, 1'b0);
    for (int k = 1; k < 8; k++) begin
      send(3'd2, 26'(k << 5), 64'h0, 64'(k * 4), 1'b0, 32'(k * 4), 1'b0);
    end
    drain();

    // Full stall: two requests fill both stages, third must wait
    or_pat = 2;
    send(3'd4, 26'h000_0020, 64'h0, 64'h1, 1'b0, 32'h1, 1'b0);
    send(3'd4, 26'h000_0040, 64'h0, 64'h2, 1'b0, 32'h2, 1'b0);
    present(3'd4, 26'h000_0060, 64'h0, 64'h3, 1'b0, 32'h3, 1'b0);
    repeat (3) do_cycle();
    chk("stall_in_ready", 64'(rdy64), 64'd0);
    chk("stall_depth", 64'(q64.size()), 64'd2);
    or_pat = 0;
    wait_accept();
    drain();

    // Asynchronous reset with both stages full
    or_pat = 2;
    send(3'd4, 26'h000_0020, 64'h0, 64'h1, 1'b0, 32'h1, 1'b0);
    send(3'd4, 26'h000_0040, 64'h0, 64'h2, 1'b0, 32'h2, 1'b0);
    in_valid = 1'b0;
    do_cycle();
    chk("full_before_reset", 64'(ov64), 64'd1);
    #2;
    resetl = 1'b0;
    #1;
    chk("async_rst_out_valid64", 64'(ov64), 64'd0);
    chk("async_rst_out_valid32", 64'(ov32), 64'd0);
    chk("async_rst_err64", 64'(err64), 64'd0);
    chk("async_rst_err32", 64'(err32), 64'd0);
    chk("async_rst_in_ready", 64'(rdy64), 64'd0);
    q64.delete();
    q32.delete();
    m_err64 = 0;
    m_err32 = 0;
    hold_v = 1'b0;
    @(negedge CLK);
    resetl = 1'b1;
    since_rst = 0;
    or_pat = 0;
    repeat (3) do_cycle();

    // Five reserved-mode requests: 2-bit counter sticks at 3
    for (int i = 0; i < 5; i++) begin
      send(3'd7, 26'($urandom), 64'h0, 64'h0, 1'b1, 32'h0, 1'b1);
    end
    drain();
    chk("err_sat32", 64'(err32), 64'd3);
    chk("err_cnt64_five", 64'(err64), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
